// File: rtl/snoop_arb_pkg.sv
// snoop_arb_pkg: shared state encoding and one-hot helper for the round-robin snoop arbiter.
package snoop_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic logic [31:0] onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/snoop_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request searching from ptr+1 modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] j;

    // Scan from farthest to nearest so the nearest candidate after ptr is the last to win.
    always_comb begin
        idx   = '0;
        j     = '0;
        valid = |req;
        for (int i = N; i >= 1; i--) begin
            j = IW'((int'(ptr) + i) % N);
            if (req[j]) idx = j;
        end
    end

endmodule

// File: rtl/snoop_arb_rr.sv
// snoop_arb_rr: binds each snooper packet to one ready core round-robin; drains packets whose core drops ready.
// Optional packet/drop statistics counters are built when SNOOP_ARB_RR_STATS_EN is defined.
module snoop_arb_rr
    import snoop_arb_pkg::*;
#(
    parameter int SN_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH    = 64,
    parameter int INC_WIDTH     = 8,
    parameter int N             = 4,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SN_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_en,
    input  logic [INC_WIDTH-1:0]     byte_inc,
    input  logic                     done,
    output logic                     rdy,
    input  logic [N-1:0]             rdy_for_sn,
    output logic [N-1:0]             rdy_for_sn_ack,
    output logic [SN_ADDR_WIDTH-1:0] sn_addr,
    output logic [DATA_WIDTH-1:0]    sn_wr_data,
    output logic [INC_WIDTH-1:0]     sn_byte_inc,
    output logic [N-1:0]             sn_wr_en,
    output logic [N-1:0]             sn_done
`ifdef SNOOP_ARB_RR_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]     pkt_cnt,
    output logic [CNT_WIDTH-1:0]     drop_cnt
`endif
);

    localparam int IW = $clog2(N);

    state_e                   state_q, state_d;
    logic [IW-1:0]            g_q, g_d, ptr_q, ptr_d;
    logic                     started_q, started_d;
    logic [N-1:0]             ack_q, ack_d, wr_en_q, wr_en_d, done_q, done_d;
    logic [SN_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [INC_WIDTH-1:0]     inc_q, inc_d;
    logic [IW-1:0]            pick_idx;
    logic                     pick_valid;
    logic                     cur_rdy, fwd;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req   (rdy_for_sn),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign cur_rdy = rdy_for_sn[g_q];
    assign fwd     = (state_q == ARMED) && cur_rdy && wr_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            g_q       <= '0;
            ptr_q     <= IW'(N - 1);
            started_q <= 1'b0;
            ack_q     <= '0;
            wr_en_q   <= '0;
            done_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            inc_q     <= '0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            ptr_q     <= ptr_d;
            started_q <= started_d;
            ack_q     <= ack_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            inc_q     <= inc_d;
        end
    end

    // done takes priority over ready loss while ARMED.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        started_d = started_q | fwd;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = ARMED;
                    g_d       = pick_idx;
                    started_d = 1'b0;
                end
            end
            ARMED: begin
                if (done) begin
                    state_d = IDLE;
                    ptr_d   = g_q;
                end else if (!cur_rdy) begin
                    state_d = started_q ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (done) begin
                    state_d = IDLE;
                    ptr_d   = g_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d   = (state_q == IDLE && pick_valid) ? N'(onehot(pick_idx)) : '0;
        wr_en_d = fwd ? N'(onehot(g_q)) : '0;
        done_d  = (state_q == ARMED && done) ? N'(onehot(g_q)) : '0;
        addr_d  = fwd ? addr : addr_q;
        data_d  = fwd ? wr_data : data_q;
        inc_d   = fwd ? byte_inc : inc_q;
    end

    assign rdy            = state_q != IDLE;
    assign rdy_for_sn_ack = ack_q;
    assign sn_wr_en       = wr_en_q;
    assign sn_done        = done_q;
    assign sn_addr        = addr_q;
    assign sn_wr_data     = data_q;
    assign sn_byte_inc    = inc_q;

`ifdef SNOOP_ARB_RR_STATS_EN
    logic [CNT_WIDTH-1:0] pkt_q, pkt_d, drop_q, drop_d;

    always_comb begin
        pkt_d  = pkt_q + CNT_WIDTH'(state_q == ARMED && done);
        drop_d = drop_q + CNT_WIDTH'(state_q == DRAIN && done);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_q  <= '0;
            drop_q <= '0;
        end else begin
            pkt_q  <= pkt_d;
            drop_q <= drop_d;
        end
    end

    assign pkt_cnt  = pkt_q;
    assign drop_cnt = drop_q;
`else
    logic [CNT_WIDTH-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_snoop_arb_rr.sv
// tb_snoop_arb_rr: directed test-plan steps plus randomized traffic checked against a packet-level behavioural model.
module tb_snoop_arb_rr;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  addr = '0;
    logic [63:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic [7:0]  byte_inc = '0;
    logic        done = 1'b0;
    logic [N-1:0] rdy_for_sn = '0;
    logic        rdy;
    logic [N-1:0] rdy_for_sn_ack, sn_wr_en, sn_done;
    logic [7:0]  sn_addr;
    logic [63:0] sn_wr_data;
    logic [7:0]  sn_byte_inc;
`ifdef SNOOP_ARB_RR_STATS_EN
    logic [31:0] pkt_cnt, drop_cnt;
`endif

    always #5 clk = ~clk;

    snoop_arb_rr dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .byte_inc       (byte_inc),
        .done           (done),
        .rdy            (rdy),
        .rdy_for_sn     (rdy_for_sn),
        .rdy_for_sn_ack (rdy_for_sn_ack),
        .sn_addr        (sn_addr),
        .sn_wr_data     (sn_wr_data),
        .sn_byte_inc    (sn_byte_inc),
        .sn_wr_en       (sn_wr_en),
        .sn_done        (sn_done)
`ifdef SNOOP_ARB_RR_STATS_EN
        ,
        .pkt_cnt        (pkt_cnt),
        .drop_cnt       (drop_cnt)
`endif
    );

    // Model: bound core (-1 when none), whether the packet is being thrown away, whether it has forwarded data.
    int          m_core = -1;
    bit          m_discard = 0;
    bit          m_started = 0;
    int          m_last = N - 1;
    logic [N-1:0] e_ack = '0, e_wr = '0, e_done = '0;
    logic [7:0]  e_addr = '0, e_inc = '0;
    logic [63:0] e_data = '0;
    int unsigned e_pkt = 0, e_drop = 0;
    int          n_pass = 0, n_fail = 0, n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        e_ack  = '0;
        e_wr   = '0;
        e_done = '0;
        if (!rst) begin
            m_core = -1; m_discard = 0; m_started = 0; m_last = N - 1;
            e_addr = '0; e_data = '0; e_inc = '0; e_pkt = 0; e_drop = 0;
        end else if (m_core < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (rdy_for_sn[(m_last + k) % N]) begin
                    m_core = (m_last + k) % N;
                    e_ack[m_core] = 1'b1;
                    m_started = 0;
                    break;
                end
            end
        end else if (m_discard) begin
            if (done) begin
                m_last = m_core; e_drop++; m_core = -1; m_discard = 0;
            end
        end else begin
            if (rdy_for_sn[m_core] && wr_en) begin
                e_wr[m_core] = 1'b1;
                e_addr = addr; e_data = wr_data; e_inc = byte_inc;
                m_started = 1;
            end
            if (done) begin
                e_done[m_core] = 1'b1;
                m_last = m_core; e_pkt++; m_core = -1;
            end else if (!rdy_for_sn[m_core]) begin
                if (m_started) m_discard = 1;
                else m_core = -1;
            end
        end
    endtask

    task automatic check_all();
        chk("rdy", 64'(rdy), 64'(m_core >= 0));
        chk("ack", 64'(rdy_for_sn_ack), 64'(e_ack));
        chk("sn_wr_en", 64'(sn_wr_en), 64'(e_wr));
        chk("sn_done", 64'(sn_done), 64'(e_done));
        chk("sn_addr", 64'(sn_addr), 64'(e_addr));
        chk("sn_wr_data", sn_wr_data, e_data);
        chk("sn_byte_inc", 64'(sn_byte_inc), 64'(e_inc));
`ifdef SNOOP_ARB_RR_STATS_EN
        chk("pkt_cnt", 64'(pkt_cnt), 64'(e_pkt));
        chk("drop_cnt", 64'(drop_cnt), 64'(e_drop));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic write_beats(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en    = 1'b1;
            addr     = 8'($urandom);
            wr_data  = {$urandom, $urandom};
            byte_inc = 8'($urandom);
            cycle();
        end
        wr_en = 1'b0;
    endtask

    int grant_seq[5] = '{0, 1, 2, 3, 0};

    initial begin
        cycle();
        cycle();
        chk("reset_rdy", 64'(rdy), 64'd0);
        chk("reset_ack", 64'(rdy_for_sn_ack), 64'd0);

        rst = 1'b1;
        rdy_for_sn = 4'b1111;
        cycle();
        chk("first_ack", 64'(rdy_for_sn_ack), 64'b0001);
        chk("first_rdy", 64'(rdy), 64'd1);

        for (int p = 0; p < 5; p++) begin
            if (p > 0) begin
                cycle();
                chk("fair_ack", 64'(rdy_for_sn_ack), 64'(1 << grant_seq[p]));
            end
            write_beats(3);
            done = 1'b1;
            cycle();
            chk("fair_done", 64'(sn_done), 64'(1 << grant_seq[p]));
            done = 1'b0;
        end
`ifdef SNOOP_ARB_RR_STATS_EN
        chk("fair_pkt_cnt", 64'(pkt_cnt), 64'd5);
`endif

        cycle();
        chk("fwd_ack", 64'(rdy_for_sn_ack), 64'b0010);
        addr = 8'h1C; wr_data = 64'hDEADBEEF_01234567; byte_inc = 8'd4;
        wr_en = 1'b1; done = 1'b1;
        cycle();
        chk("fwd_wr", 64'(sn_wr_en), 64'b0010);
        chk("fwd_done", 64'(sn_done), 64'b0010);
        chk("fwd_addr", 64'(sn_addr), 64'h1C);
        chk("fwd_data", sn_wr_data, 64'hDEADBEEF_01234567);
        chk("fwd_inc", 64'(sn_byte_inc), 64'd4);
        wr_en = 1'b0; done = 1'b0;

        rdy_for_sn = 4'b0010;
        cycle();
        chk("loss_ack", 64'(rdy_for_sn_ack), 64'b0010);
        rdy_for_sn = 4'b1111;
        write_beats(2);
        rdy_for_sn = 4'b1101;
        wr_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("loss_no_wr", 64'(sn_wr_en), 64'd0);
            chk("loss_rdy", 64'(rdy), 64'd1);
        end
        wr_en = 1'b0; done = 1'b1;
        cycle();
        chk("loss_no_done", 64'(sn_done), 64'd0);
        chk("loss_rdy_low", 64'(rdy), 64'd0);
        done = 1'b0;
`ifdef SNOOP_ARB_RR_STATS_EN
        chk("loss_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
        rdy_for_sn = 4'b1111;
        cycle();
        chk("loss_next_ack", 64'(rdy_for_sn_ack), 64'b0100);

        rdy_for_sn = 4'b1011;
        cycle();
        chk("early_loss_idle", 64'(rdy), 64'd0);
        cycle();
        chk("early_loss_regrant", 64'(rdy_for_sn_ack), 64'b1000);
`ifdef SNOOP_ARB_RR_STATS_EN
        chk("early_loss_drop", 64'(drop_cnt), 64'd1);
`endif
        rdy_for_sn = 4'b1111;

        write_beats(1);
        rst = 1'b0; wr_en = 1'b1;
        cycle();
        chk("rst_wr", 64'(sn_wr_en), 64'd0);
        chk("rst_done", 64'(sn_done), 64'd0);
        chk("rst_rdy", 64'(rdy), 64'd0);
        chk("rst_addr", 64'(sn_addr), 64'd0);
        chk("rst_data", sn_wr_data, 64'd0);
`ifdef SNOOP_ARB_RR_STATS_EN
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        rst = 1'b1; wr_en = 1'b0;
        cycle();
        chk("rst_regrant", 64'(rdy_for_sn_ack), 64'b0001);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) == 0) rdy_for_sn = N'(1 << $urandom_range(0, N - 1));
            else for (int b = 0; b < N; b++) rdy_for_sn[b] = ($urandom_range(0, 7) != 0);
            wr_en    = 1'($urandom_range(0, 1));
            done     = ($urandom_range(0, 5) == 0);
            addr     = 8'($urandom);
            wr_data  = {$urandom, $urandom};
            byte_inc = 8'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/snoop_arb_rr.md
# snoop_arb_rr

Round-robin snoop arbiter that binds each packet from the single snooper to exactly one ready packetfilter core for the whole packet. It sits between the snooper and the N packetfilter cores. Unlike the tag-tree arbiter, it grants cores fairly, registers all core-side outputs, and tolerates a core dropping ready mid-packet by draining the rest of that packet. It can optionally count forwarded and dropped packets.

## Interface
Parameters:
- SN_ADDR_WIDTH, 8: snooper write address width.
- DATA_WIDTH, 64: write data width.
- INC_WIDTH, 8: byte-increment field width.
- N, 4: number of packetfilter cores, ≥2.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- addr  in  SN_ADDR_WIDTH  snooper write address.
- wr_data  in  DATA_WIDTH  snooper write data.
- wr_en  in  1  snooper write strobe.
- byte_inc  in  INC_WIDTH  snooper byte increment.
- done  in  1  snooper end-of-packet pulse.
- rdy  out  1  a core is bound; the snooper may write.
- rdy_for_sn  in  N  per-core ready.
- rdy_for_sn_ack  out  N  one-hot, one-cycle claim pulse to the granted core.
- sn_addr  out  SN_ADDR_WIDTH  registered address.
- sn_wr_data  out  DATA_WIDTH  registered data.
- sn_byte_inc  out  INC_WIDTH  registered byte increment.
- sn_wr_en  out  N  one-hot write strobe.
- sn_done  out  N  one-hot end-of-packet pulse.
- pkt_cnt  out  CNT_WIDTH  packets delivered. Present only with the stats macro.
- drop_cnt  out  CNT_WIDTH  packets drained. Present only with the stats macro.

## Operation
The block has three states: IDLE, ARMED and DRAIN. The registers are `g` (granted index), `ptr` (last granted index) and `started` (≥1 write forwarded in the current packet).

- **IDLE**
  - rdy=0; wr_en and done are ignored.
  - If rdy_for_sn≠0, pick `g` as the first set bit searching from ptr+1, wrapping modulo N.
  - Then pulse rdy_for_sn_ack[g], clear `started`, and go to ARMED.
- **ARMED**
  - rdy=1.
  - If rdy_for_sn[g]=1 and wr_en=1: forward addr, wr_data and byte_inc, strobe sn_wr_en[g], and set `started`.
  - If done=1: pulse sn_done[g], set ptr←g, increment pkt_cnt, and go to IDLE. This applies even when rdy_for_sn[g] is low in the same cycle, so done wins.
  - Else, if rdy_for_sn[g]=0:
    - with `started` clear, go to IDLE with no drop counted;
    - with `started` set, go to DRAIN.
    - In either case, writes sampled in that cycle are discarded.
- **DRAIN**
  - rdy=1; all writes are discarded.
  - On done: no sn_done pulse, set ptr←g, increment drop_cnt, and go to IDLE.
- **Round-robin pointer:** ptr resets to N-1, so core 0 wins the first grant when all cores are ready.
- **Data path registers:** sn_addr, sn_wr_data and sn_byte_inc load on every forwarded write and hold otherwise.
- **Counters:** both wrap modulo 2^CNT_WIDTH.

## Timing
- **Reset values (rst=0 at an edge):**
  - state=IDLE, ptr=N-1, `started`=0;
  - rdy=0; rdy_for_sn_ack, sn_wr_en and sn_done all 0;
  - sn_addr, sn_wr_data and sn_byte_inc all 0; counters 0.
  - A reset mid-packet abandons the packet silently, with no sn_done pulse and no drop count.
- **Grant:** ready sampled in IDLE at edge t gives state ARMED, rdy=1 and rdy_for_sn_ack[g]=1 after edge t. The ack is high for exactly one cycle.
- **Write latency:** wr_en sampled in ARMED at edge t drives sn_wr_en[g] and the data outputs after edge t. This is one cycle of latency, with one write per cycle.
- **done:** done at edge t gives sn_done[g] and rdy=0 after edge t.
  - wr_en and done in the same cycle: the last write and sn_done appear together.
  - The next grant is sampled at edge t+1.
  - Minimum packet-to-packet gap is one IDLE cycle.
- **Ready loss:** rdy_for_sn[g] falling is acted on at the first edge where it is sampled low.
- **Single core:** with only one core ever ready, that core is granted every packet.
- **No cores ready:** remain in IDLE indefinitely.

## Configuration
- **SNOOP_ARB_RR_STATS_EN defined:** pkt_cnt and drop_cnt ports and counters exist as specified.
- **SNOOP_ARB_RR_STATS_EN undefined:** the ports and counters are absent, and all other behaviour is identical.

## Structure
- **Shared package snoop_arb_pkg:**
  - state encoding constants IDLE=2'd0, ARMED=2'd1, DRAIN=2'd2;
  - a one-hot-from-index helper function.
- **Sub-module rr_pick:**
  - combinational round-robin picker;
  - inputs: req[N], ptr;
  - outputs: idx, valid.
- **Top level:** FSM, output registers and counters.

## Test plan
- **Reset and first grant:** reset, then rdy_for_sn=4'b1111 → ack=4'b0001 one cycle after sampling; rdy=1.
- **Fairness:** all cores ready; send 5 packets of 3 writes each → grants go to cores 0,1,2,3,0; each packet gives 3 sn_wr_en pulses on its core; pkt_cnt=5.
- **Write forwarding:** in ARMED, drive addr=8'h1C, wr_data=64'hDEADBEEF_01234567, byte_inc=4 with done on the same cycle → one cycle later sn_wr_en[g] and sn_done[g] are both high and the outputs match the inputs.
- **Mid-packet ready loss:** core 1 granted; after 2 writes, rdy_for_sn[1]=0 → no further sn_wr_en[1]; rdy stays 1 until done; no sn_done; drop_cnt=1; next grant goes to core 2.
- **Ready loss before first write:** rdy_for_sn[g] low before any write → return to IDLE; drop_cnt unchanged; re-grant on the next ready core.
- **Reset mid-packet:** reset asserted during ARMED after 1 write → all outputs 0 next cycle; no sn_done; counters 0; ptr=3.
